// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: round count, FK words,
// CK generator and the expansion FSM state type.
package sm4_pkg;

  localparam int NUM_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'ha3b1bac6;
  localparam logic [31:0] FK1 = 32'h56aa3350;
  localparam logic [31:0] FK2 = 32'h677d9197;
  localparam logic [31:0] FK3 = 32'hb27022dc;

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } state_e;

  // CK[i] byte j (j=0 is the MSB) is ((4i+j)*7) mod 256;
  // the 8-bit product truncates, which is the mod.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [7:0]  idx;
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'b00} + 8'(j);
      w[31-8*j -: 8] = idx * 8'd7;
    end
    return w;
  endfunction

endpackage

// File: rtl/sm4_key_schedule_one_round.sv
// One SM4 key-expansion round: state_i/ck_i/round_i in,
// next 128-bit state and the new round key out.
module one_round_for_key_exp
  import sm4_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [31:0]  ck_i,
  input  logic [4:0]   round_i,
  output logic [127:0] state_o,
  output logic [31:0]  rk_o
);

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry a sits at bit (255-a)*8, i.e. {~a,3'b0}.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]),
            sbox(a[15:8]),  sbox(a[7:0])};
  endfunction

  logic [127:0] x;
  logic [31:0]  k0, k1, k2, k3, k4;
  logic [31:0]  b;

  // FK whitening is folded into the first round so the
  // state register holds the raw master key at acceptance.
  assign x = (round_i == 5'd0) ?
             (state_i ^ {FK0, FK1, FK2, FK3}) : state_i;

  assign k0 = x[127:96];
  assign k1 = x[95:64];
  assign k2 = x[63:32];
  assign k3 = x[31:0];

  assign b  = tau(k1 ^ k2 ^ k3 ^ ck_i);
  assign k4 = k0 ^ b ^ {b[18:0], b[31:19]}
                     ^ {b[8:0], b[31:9]};

  assign state_o = {k1, k2, k3, k4};
  assign rk_o    = k4;

endmodule

// File: rtl/sm4_key_schedule.sv
// SM4 key expansion: accepts a 128-bit master key, runs 32
// rounds (one per cycle) into a 32x32 round-key file.
// Ports: clk/rst, key_valid_in/key_in/key_ready_out handshake,
// busy_out, done_out pulse, keys_valid_out, and a combinational
// read port rk_rd_addr_in/rk_rd_rev_in -> rk_rd_data_out.
module sm4_key_schedule
  import sm4_pkg::*;
#(
  parameter int NUM_ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid_in,
  input  logic [127:0] key_in,
  output logic         key_ready_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         keys_valid_out,
  input  logic [4:0]   rk_rd_addr_in,
  input  logic         rk_rd_rev_in,
  output logic [31:0]  rk_rd_data_out
);

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic         done_q, done_d;
  logic         kv_q, kv_d;
  logic         rk_we;
  logic [31:0]  rf_q [NUM_ROUNDS];

  logic [127:0] rnd_state;
  logic [31:0]  rnd_rk;
  logic [4:0]   rd_idx;

  one_round_for_key_exp u_round (
    .state_i (st_q),
    .ck_i    (ck_word(cnt_q)),
    .round_i (cnt_q),
    .state_o (rnd_state),
    .rk_o    (rnd_rk)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    rk_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_valid_in) begin
          st_d    = key_in;
          cnt_d   = 5'd0;
          kv_d    = 1'b0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        st_d  = rnd_state;
        rk_we = 1'b1;
        cnt_d = cnt_q + 5'd1;
        // Exit on the last round; the counter never wraps.
        if (cnt_q == LAST) begin
          cnt_d   = 5'd0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      st_q    <= '0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rk_we) begin
      rf_q[cnt_q] <= rnd_rk;
    end
  end

  assign rd_idx = rk_rd_rev_in ? (LAST - rk_rd_addr_in)
                               : rk_rd_addr_in;

  assign rk_rd_data_out = rf_q[rd_idx];
  assign key_ready_out  = (state_q == S_IDLE);
  assign busy_out       = (state_q == S_EXPAND);
  assign done_out       = done_q;
  assign keys_valid_out = kv_q;

endmodule

// File: doc/sm4_key_schedule.md
SM4_KEY_SCHEDULE -- requirements
Module: sm4_key_schedule

Interface
REQ-001 Parameter NUM_ROUNDS, default 32, SHALL set the number of round keys generated; only 32 is supported.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port key_valid_in, input, 1, a master key is presented on key_in.
REQ-006 Port key_in, input, 128, master key MK, with word MK0 in bits [127:96].
REQ-007 Port key_ready_out, output, 1, the block accepts a key this cycle.
REQ-008 Port busy_out, output, 1, expansion in progress.
REQ-009 Port done_out, output, 1, one-cycle pulse when all round keys are written.
REQ-010 Port keys_valid_out, output, 1, the stored rk[0..31] belong to the last accepted key.
REQ-011 Port rk_rd_addr_in, input, 5, round-key read index.
REQ-012 Port rk_rd_rev_in, input, 1, reverse order for decryption: reads rk[31-addr].
REQ-013 Port rk_rd_data_out, output, 32, combinational read of the selected round key.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and EXPAND.
REQ-015 key_ready_out SHALL equal (state==IDLE).
- Acceptance occurs on the rising edge where key_valid_in and key_ready_out are both high.
REQ-016 On acceptance, the block SHALL capture key_in unmodified into a 128-bit state register, clear the round counter to 0, clear keys_valid_out and enter EXPAND.
REQ-017 In EXPAND, each cycle SHALL compute one round through the single-round datapath.
- The datapath is driven by: the state register, CK[round] and the round counter.
- The round-0 FK XOR is done inside the datapath.
- On each edge: the new 128-bit state is registered, its low word is written to rk[round], and the round counter increments.
REQ-018 CK[i] byte j (j=0 is MSB) SHALL equal ((4i+j)*7) mod 256.
- CK[0]=32'h00070e15, CK[1]=32'h1c232a31, CK[31]=32'h646b7279.
REQ-019 The write of rk[31] SHALL return the FSM to IDLE; done_out SHALL be high and keys_valid_out set in the following cycle.
- Latency: done_out is high in the cycle beginning 32 edges after the acceptance edge.
REQ-020 busy_out SHALL equal (state==EXPAND).
REQ-021 key_valid_in during EXPAND SHALL be ignored and SHALL NOT disturb the expansion.
REQ-022 Back-to-back operation: a key may be accepted in the same cycle done_out is high.
- That acceptance clears keys_valid_out on the same edge.
- Throughput is one key per 33 cycles.
REQ-023 Reads SHALL be legal at any time.
- During EXPAND, reads return partially updated storage; consumers SHALL gate on keys_valid_out.
REQ-024 The round counter SHALL be 5 bits and SHALL NOT wrap into a 33rd round; the exit condition is counter==31.

Reset
REQ-025 rst SHALL force state IDLE, round counter 0, state register 0, all rk entries 0, done_out 0, keys_valid_out 0.
- Resulting outputs: busy_out 0, key_ready_out 1, rk_rd_data_out 0.
REQ-026 rst asserted mid-EXPAND SHALL abort the expansion with no done_out pulse.
- After reset the next accepted key SHALL be expanded from scratch.
REQ-027 rst SHALL take priority over acceptance in the same cycle.

Structure
REQ-028 Shared package sm4_pkg SHALL hold: NUM_ROUNDS, the 32-entry CK constant table (or its generating function), the FSM state typedef, and FK0..FK3.
REQ-029 The block SHALL instantiate exactly one sub-module, one_round_for_key_exp, as the per-round datapath.
- The FSM, counter, CK selection and 32x32 round-key register file are local to this module.

Verification
REQ-030 Standard vector: MK=0123456789abcdeffedcba9876543210, accepted at edge E0, then:
- rk[0]=f12186f9, rk[1]=41662b61, rk[31]=9124a012;
- done_out high exactly 32 edges after E0;
- keys_valid_out=1 afterwards.
REQ-031 Reverse read: after REQ-030 completes, addr=0 with rk_rd_rev_in=1 -> rk_rd_data_out=9124a012; addr=31 with rk_rd_rev_in=1 -> f12186f9.
REQ-032 Hold key_valid_in high with key 00..00 during the REQ-030 expansion:
- the key is ignored and REQ-030 results are unchanged;
- the all-zero key is accepted in the done_out cycle;
- keys_valid_out drops on that edge and rises 33 cycles later.
REQ-033 Assert rst for one cycle at round 10:
- no done_out pulse, all rk read 0, key_ready_out=1 the next cycle;
- re-issuing the REQ-030 key then yields the REQ-030 results.
REQ-034 Random regression: 1000 random keys with random idle gaps; all 32 rk values must match a reference model, and done_out must pulse once per accepted key.
